x_shift_32_sched: RTL
=====================

# x_shift_32_sched

Two-requester scheduler that shares one 32-bit serial shift line between two word-wide clients. It arbitrates requests round-robin and serializes each accepted 32-bit word MSB-first onto the line. It then deserializes the bits returning from the line's far end and hands the word back tagged with the originating requester ID. It sits directly in front of the 32-stage serial shift chain, driving its input bit and sampling its output bit.

## Interface
Parameters:
- LAT, 32, cycles from a bit driven on o_sh_in to the same bit on i_sh_out; legal range 1..32.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- i_req_valid  in  2  per-requester word valid, bit i = requester i
- o_req_ready  out  2  per-requester accept; one-hot or zero
- i_req_data0  in  32  requester 0 word
- i_req_data1  in  32  requester 1 word
- o_sh_in  out  1  serial bit to shift line input
- i_sh_out  in  1  serial bit from shift line output
- o_rsp_valid  out  1  one-cycle pulse, returned word valid
- o_rsp_id  out  1  requester that sent the returned word
- o_rsp_data  out  32  returned word
- o_busy  out  1  any frame in transmit or in flight
- o_err  out  1  sticky self-check mismatch (see Configuration)

## Operation
- Reset is synchronous, active-low, on i_clk. The shift line shares i_rst_n.
- Reset values: o_req_ready=0 for the reset cycle, o_sh_in=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_busy=0, o_err=0. The round-robin pointer is reset so requester 0 wins the first contention.
- TX FSM states:
  - IDLE: no frame being sent.
  - SEND: a 5-bit bit counter runs 0..31; o_sh_in = word[31-cnt], registered.
- Accept condition: the transmitter can accept when it is in IDLE, or in SEND with cnt==31, which allows zero-gap streaming.
- Arbitration is combinational from i_req_valid and the pointer:
  - Single valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
- o_req_ready = grant & {2{can_accept}}. A handshake is valid & ready at a clock edge.
- On handshake:
  - Latch the word and ID, move the pointer to the granted ID, and enter SEND with cnt=0.
  - Push the ID, plus the word when the check is compiled in, onto a 2-entry in-flight queue.
- When SEND completes cnt==31 with no new handshake, go to IDLE; o_sh_in returns to 0.
- RX: a LAT-stage delayed copy of the TX "bit valid" strobe, plus a delayed "first bit" marker, qualifies i_sh_out.
  - Qualified bits shift left into a 32-bit assembly register, so the word is reconstructed unchanged.
  - After the 32nd qualified bit: the register writes o_rsp_data, o_rsp_id comes from the queue head, o_rsp_valid pulses for 1 cycle, and the queue pops.
- No response backpressure; the consumer must take the word on the pulse.
- o_busy = TX in SEND, or queue non-empty.
- The queue cannot overflow. At most ceil(LAT/32)+1 ≤ 2 frames are in flight, and a push and pop in the same cycle is legal.
- Reset mid-operation drops all frames: no response is issued for them, the queue empties, and o_sh_in goes to 0.

## Timing
- Handshake at the end of cycle G: bit 31 of the word is on o_sh_in in cycle G+1, and bit 0 in cycle G+32.
- The first returned bit is on i_sh_out in cycle G+1+LAT. o_rsp_valid is high in cycle G+33+LAT, which is cycle G+65 for LAT=32.
- Back-to-back: the next handshake may land in cycle G+32, giving 0 idle bits on the line. Responses are then spaced exactly 32 cycles apart.
- o_req_ready is combinational from i_req_valid and state. i_req_data must be stable while valid is high.

## Configuration
- X_SHIFT_32_SCHED_CHECK_EN defined:
  - The queue also stores the sent word.
  - On each response, o_rsp_data is compared with the stored word. A mismatch sets o_err, which stays set until reset.
- Undefined: the queue stores the ID only, o_err is tied to 0, and no compare logic is built.

## Test plan
- Single request: data0=0xA5A5_0F0F accepted at cycle G with LAT=32. Expect o_sh_in to carry 1,0,1,0,… MSB-first over G+1..G+32, then o_rsp_valid, o_rsp_id=0 and o_rsp_data=0xA5A5_0F0F in cycle G+65, with o_err=0.
- Contention: both requesters held valid with data0=0x1, data1=0x2. Grants alternate 0,1,0 at 32-cycle intervals. Responses return in the same order with matching IDs and data, 32 cycles apart, and o_busy stays high throughout.
- Streaming: requester 1 valid continuously with an incrementing word. Expect ready every 32nd cycle, no idle bits on o_sh_in, and every response exact.
- Mid-frame reset: assert i_rst_n=0 at bit 10 of the first frame. Expect all outputs at reset values next cycle, and no o_rsp_valid pulse at G+65.
- Corruption, with the macro defined: invert i_sh_out for one bit. Expect the response data to differ in that bit and o_err=1 to stay set. With the macro undefined, o_err stays 0.
- LAT=1 build: request 0xFFFF_0000. Expect the response at G+34 with correct data.

Source files
------------

// File: rtl/x_shift_32_sched.sv
// x_shift_32_sched: round-robin scheduler sharing one 32-bit serial shift line
// between two word clients. Optional sent-word self-check: X_SHIFT_32_SCHED_CHECK_EN.
module x_shift_32_sched #(
    parameter int LAT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req_valid,
    output logic [1:0]  o_req_ready,
    input  logic [31:0] i_req_data0,
    input  logic [31:0] i_req_data1,
    output logic        o_sh_in,
    input  logic        i_sh_out,
    output logic        o_rsp_valid,
    output logic        o_rsp_id,
    output logic [31:0] o_rsp_data,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic {S_IDLE, S_SEND} tx_state_e;

    tx_state_e         state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              sh_in_q, sh_in_d;
    logic              last_q, last_d;
    logic [LAT-1:0]    vpipe_q, vpipe_d;
    logic [LAT-1:0]    fpipe_q, fpipe_d;
    logic [31:0]       asm_q, asm_d;
    logic [4:0]        rcnt_q, rcnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        qid_q, qid_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        qcnt_q, qcnt_d;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
    logic [1:0][31:0]  qword_q, qword_d;
    logic              err_q, err_d;
`endif

    logic [1:0]  grant;
    logic [1:0]  hs_vec;
    logic        can_accept;
    logic        hs_any;
    logic        hs_id;
    logic [31:0] hs_data;
    logic        rx_v;
    logic        rx_first;
    logic [4:0]  rx_idx;
    logic        pop;

    assign can_accept  = (state_q == S_IDLE) || (cnt_q == 5'd31);
    assign o_req_ready = grant & {2{can_accept & i_rst_n}};
    assign hs_vec      = i_req_valid & o_req_ready;
    assign hs_any      = |hs_vec;
    assign hs_id       = hs_vec[1];
    assign hs_data     = hs_id ? i_req_data1 : i_req_data0;
    assign rx_v        = vpipe_q[LAT-1];
    assign rx_first    = fpipe_q[LAT-1];

    // Round-robin grant: on contention favour the requester not granted last.
    always_comb begin
        grant = 2'b00;
        case (i_req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // TX FSM: load on handshake, shift the word out MSB-first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sh_in_d = sh_in_q;
        last_d  = last_q;
        if (hs_any) begin
            state_d = S_SEND;
            cnt_d   = 5'd0;
            word_d  = hs_data;
            sh_in_d = hs_data[31];
            last_d  = hs_id;
        end else if (state_q == S_SEND) begin
            if (cnt_q == 5'd31) begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
                sh_in_d = 1'b0;
            end else begin
                cnt_d   = cnt_q + 5'd1;
                sh_in_d = word_q[5'd30 - cnt_q];
            end
        end
    end

    // Bit-valid and first-bit strobes delayed to match the line latency.
    always_comb begin
        vpipe_d    = vpipe_q;
        fpipe_d    = fpipe_q;
        vpipe_d[0] = (state_q == S_SEND);
        fpipe_d[0] = (state_q == S_SEND) && (cnt_q == 5'd0);
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            fpipe_d[i] = fpipe_q[i-1];
        end
    end

    // RX assembly, response generation and in-flight queue bookkeeping.
    always_comb begin
        asm_d       = asm_q;
        rcnt_d      = rcnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        rx_idx      = rx_first ? 5'd0 : rcnt_q;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
        err_d       = err_q;
        qword_d     = qword_q;
`endif
        if (rx_v) begin
            asm_d  = {asm_q[30:0], i_sh_out};
            rcnt_d = rx_idx + 5'd1;
            if (rx_idx == 5'd31) begin
                pop         = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_id_d    = qid_q[rd_q];
                rsp_data_d  = asm_d;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
                err_d       = err_q | (asm_d != qword_q[rd_q]);
`endif
            end
        end
        qid_d = qid_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (hs_any) begin
            qid_d[wr_q] = hs_id;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
            qword_d[wr_q] = hs_data;
`endif
            wr_d = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        qcnt_d = qcnt_q + {1'b0, hs_any} - {1'b0, pop};
    end

    // State registers; reset drops every frame in transmit or in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            sh_in_q     <= 1'b0;
            last_q      <= 1'b1;
            vpipe_q     <= '0;
            fpipe_q     <= '0;
            asm_q       <= '0;
            rcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            qid_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            qcnt_q      <= '0;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
            qword_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            sh_in_q     <= sh_in_d;
            last_q      <= last_d;
            vpipe_q     <= vpipe_d;
            fpipe_q     <= fpipe_d;
            asm_q       <= asm_d;
            rcnt_q      <= rcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            qid_q       <= qid_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            qcnt_q      <= qcnt_d;
`ifdef X_SHIFT_32_SCHED_CHECK_EN
            qword_q     <= qword_d;
            err_q       <= err_d;
`endif
        end
    end

    assign o_sh_in     = sh_in_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = (state_q == S_SEND) || (qcnt_q != 2'd0);
`ifdef X_SHIFT_32_SCHED_CHECK_EN
    assign o_err       = err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule
